moore_1010_seq_gen: RTL and testbench
=====================================

// Module: moore_1010_seq_gen
// PURPOSE
//  Serial pattern transmitter for the Moore sequence-detector family. It drives a detector's 1-bit
//  `in` with a programmable pattern (default 1010), MSB first, repeated N times with an optional
//  idle gap between repetitions. Gap 0 produces back-to-back overlapping streams for detector stimulus.
//  Outputs are Moore-style: registered and decoded from state and datapath registers only.
// PARAMETERS
//  PAT_W        4        pattern length in bits; must be >= 2
//  CNT_W        4        width of repetition count
//  GAP_W        3        width of inter-repetition gap count (cycles)
//  DEFAULT_PAT  4'b1010  pattern register value after reset
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst        in   1      reset; synchronous, active-high
//  start      in   1      request; accepted only when busy==0 and abort==0
//  pattern    in   PAT_W  pattern captured on accept; bit PAT_W-1 is sent first
//  reps       in   CNT_W  number of repetitions captured on accept; 0 = send nothing
//  gap        in   GAP_W  idle cycles between repetitions, captured on accept
//  abort      in   1      terminate current transfer
//  out        out  1      serial bit to detector `in`; 0 whenever out_valid==0
//  out_valid  out  1      out carries a pattern bit this cycle
//  busy       out  1      transfer in progress (SHIFT or GAP)
//  done       out  1      1-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: state=IDLE; out=0, out_valid=0, busy=0, done=0; pattern reg=DEFAULT_PAT; counters=0.
//  A rst asserted mid-transfer yields reset values on the next edge; no done pulse.
//  States:
//   - IDLE: outputs 0.
//   - SHIFT: out=pattern reg bit[idx], out_valid=1, busy=1.
//   - GAP: out=0, out_valid=0, busy=1.
//   - DONE: done=1, busy=0; lasts exactly 1 cycle.
//  Accept: start=1 in IDLE or DONE with abort=0 at edge k.
//   - Capture pattern, reps and gap; later input changes are ignored until the next accept.
//   - reps!=0: SHIFT from edge k, with idx=PAT_W-1. First bit is visible in the cycle after edge k.
//   - reps==0: go to DONE; done pulses, no bit is emitted.
//  start while busy=1 is ignored. From DONE with no start: go to IDLE.
//  SHIFT: idx decrements once per cycle. At idx==0, with rep_left decremented:
//   - rep_left==0: go to DONE.
//   - else gap==0: idx=PAT_W-1 and stay in SHIFT. There is no bubble between repetitions.
//   - else: go to GAP with gap_cnt=gap.
//  GAP: gap_cnt decrements. At gap_cnt==1: idx=PAT_W-1 and go to SHIFT.
//  Totals: reps*PAT_W valid bits; done asserts reps*PAT_W + (reps-1)*gap cycles after first bit.
//  abort=1 while busy: next edge goes to IDLE with all outputs 0; no done pulse.
//   - abort beats start in the same cycle.
//   - abort in IDLE/DONE blocks an accept that cycle; DONE still goes to IDLE.
//  Counters never wrap: reps up to 2^CNT_W-1, gap up to 2^GAP_W-1.
// STRUCTURE
//  Package moore_seq_pkg holds:
//   - state localparams IDLE=2'd0, SHIFT=2'd1, GAP=2'd2, DONE=2'd3;
//   - DEFAULT_PAT;
//   - the shared PAT_W/CNT_W/GAP_W defaults.
//  One sub-module, seq_piso: PAT_W-bit parallel-load register plus idx counter and bit mux.
//  The top level holds the FSM, the rep_left and gap_cnt down-counters, and the output registers.
// TESTING
//  1 rst 2 cycles; start with pattern=1010, reps=1, gap=0 -> out 1,0,1,0 with valid=1 on cycles 1-4
//    after accept; done=1 on cycle 5; busy=1 on cycles 1-4 only.
//  2 reps=3, gap=0 -> 101010101010 with no valid gaps; a chained moore_1010 detector flags
//    5 overlapping hits.
//  3 reps=2, gap=2 -> valid pattern 1,1,1,1,0,0,1,1,1,1 (bits 1010,--,1010); out=0 during the gap;
//    done on cycle 11.
//  4 reps=2, abort during the third bit -> next cycle out=0, valid=0, busy=0; done never pulses.
//  5 start pulsed while busy with pattern=1111 -> ignored, stream stays 1010;
//    reps=0 -> done next cycle, valid never asserts.
//  6 rst during GAP -> all outputs 0 next edge; new start then sends DEFAULT_PAT only if
//    pattern=1010 is driven.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// Shared types and defaults for the Moore sequence-detector stimulus family.
package moore_seq_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP_W = 3;

    localparam logic [DEF_PAT_W-1:0] DEFAULT_PAT = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load pattern register with a descending bit index; presents the
// indexed bit and flags when the index has reached bit 0.
module seq_piso #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             restart,
    input  logic             advance,
    input  logic [PAT_W-1:0] pat,
    output logic             data,
    output logic             last
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-1:0] pat_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic [PAT_W-1:0] bit_hit;

    always_comb begin
        pat_next = pat_reg;
        idx_next = idx_reg;
        if (load) begin
            pat_next = pat;
        end
        if (load || restart) begin
            idx_next = IDX_TOP;
        end else if (advance) begin
            idx_next = idx_reg - IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg <= DEFAULT_PAT;
            idx_reg <= '0;
        end else begin
            pat_reg <= pat_next;
            idx_reg <= idx_next;
        end
    end

    // One-hot select keeps the mux a flat AND-OR tree.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mux
            assign bit_hit[gi] = pat_reg[gi] & (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign data = |bit_hit;
    assign last = (idx_reg == '0);

endmodule

// File: rtl/moore_1010_seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB first, reps times,
// with an optional idle gap between repetitions.
module moore_1010_seq_gen #(
    parameter int               PAT_W       = moore_seq_pkg::DEF_PAT_W,
    parameter int               CNT_W       = moore_seq_pkg::DEF_CNT_W,
    parameter int               GAP_W       = moore_seq_pkg::DEF_GAP_W,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = moore_seq_pkg::DEFAULT_PAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    import moore_seq_pkg::*;

    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] rep_reg,     rep_next;
    logic [GAP_W-1:0] gap_reg,     gap_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;

    logic piso_load;
    logic piso_restart;
    logic piso_advance;
    logic piso_data;
    logic piso_last;

    seq_piso #(
        .PAT_W       (PAT_W),
        .DEFAULT_PAT (DEFAULT_PAT)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (piso_load),
        .restart (piso_restart),
        .advance (piso_advance),
        .pat     (pattern),
        .data    (piso_data),
        .last    (piso_last)
    );

    always_comb begin
        state_next   = state_reg;
        rep_next     = rep_reg;
        gap_next     = gap_reg;
        gap_cnt_next = gap_cnt_reg;
        piso_load    = 1'b0;
        piso_restart = 1'b0;
        piso_advance = 1'b0;

        unique case (state_reg)
            IDLE, DONE: begin
                if (start && !abort) begin
                    piso_load  = 1'b1;
                    rep_next   = reps;
                    gap_next   = gap;
                    state_next = (reps != '0) ? SHIFT : DONE;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (piso_last) begin
                    rep_next = rep_reg - CNT_W'(1);
                    if (rep_reg == CNT_W'(1)) begin
                        state_next = DONE;
                    end else if (gap_reg == '0) begin
                        piso_restart = 1'b1;
                    end else begin
                        gap_cnt_next = gap_reg;
                        state_next   = GAP;
                    end
                end else begin
                    piso_advance = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gap_cnt_reg == GAP_W'(1)) begin
                    piso_restart = 1'b1;
                    state_next   = SHIFT;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            rep_reg     <= '0;
            gap_reg     <= '0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rep_reg     <= rep_next;
            gap_reg     <= gap_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Outputs depend only on registered state and the registered pattern/index.
    assign out_valid = (state_reg == SHIFT);
    assign out       = out_valid & piso_data;
    assign busy      = (state_reg == SHIFT) || (state_reg == GAP);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_moore_1010_seq_gen.sv
// Bench for moore_1010_seq_gen: table vectors, hand-written corner sequences
// and randomized transfers against a stream-building reference model.
module tb_moore_1010_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pattern = 4'd0;
    logic [3:0] reps = 4'd0;
    logic [2:0] gap = 3'd0;
    logic       abort = 1'b0;
    logic       out, out_valid, busy, done;

    int total = 0;
    int bad   = 0;

    moore_1010_seq_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .reps      (reps),
        .gap       (gap),
        .abort     (abort),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pat;
        logic [3:0] n;
        logic [2:0] g;
        int         abort_at;
        bit         poke;
        int         exp_valid;
        int         exp_done;
        int         exp_hits;
    } vec_t;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got={out,valid,busy,done}=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Called just after a posedge with the DUT idle. Builds the expected
    // per-cycle output stream from the transfer rules, then compares.
    task automatic run(input logic [3:0] p, input logic [3:0] n, input logic [2:0] g,
                       input int abort_at, input bit poke,
                       output int nvalid, output int done_cyc, output int hits);
        logic [3:0] q[$];
        logic [3:0] got;
        logic [3:0] win;
        int         nshift;
        for (int r = 0; r < int'(n); r++) begin
            for (int b = 3; b >= 0; b--) q.push_back({p[b], 3'b110});
            if (r != int'(n) - 1)
                for (int k = 0; k < int'(g); k++) q.push_back(4'b0010);
        end
        q.push_back(4'b0001);
        q.push_back(4'b0000);
        if (abort_at > 0) begin
            while (q.size() > abort_at) void'(q.pop_back());
            q.push_back(4'b0000);
            q.push_back(4'b0000);
        end

        start = 1'b1; pattern = p; reps = n; gap = g; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; pattern = 4'($urandom); reps = 4'($urandom); gap = 3'($urandom);

        nvalid = 0; done_cyc = 0; hits = 0; win = 4'd0; nshift = 0;
        foreach (q[i]) begin
            @(negedge clk);
            got = {out, out_valid, busy, done};
            check("cycle", got, q[i]);
            if (out_valid) nvalid++;
            win = {win[2:0], out};
            nshift++;
            if (nshift >= 4 && win == 4'b1010) hits++;
            if (done && done_cyc == 0) done_cyc = i + 1;
            if (abort_at == i + 1) abort = 1'b1;
            if (poke && q[i][1] && i == 1) begin
                start = 1'b1; pattern = 4'b1111; reps = 4'd1;
            end
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0;
        end
        $display("xfer pat=%b reps=%0d gap=%0d abort_at=%0d valid=%0d done_cyc=%0d hits=%0d",
                 p, n, g, abort_at, nvalid, done_cyc, hits);
    endtask

    vec_t vecs[7];

    initial begin
        int nv, dc, ht, a;
        logic [3:0] rn;

        vecs[0] = '{4'b1010, 4'd1,  3'd0, -1, 1'b0, 4,  5,   1};
        vecs[1] = '{4'b1010, 4'd3,  3'd0, -1, 1'b0, 12, 13,  5};
        vecs[2] = '{4'b1010, 4'd2,  3'd2, -1, 1'b0, 8,  11,  2};
        vecs[3] = '{4'b1010, 4'd2,  3'd0,  3, 1'b0, 3,  0,   1};
        vecs[4] = '{4'b1010, 4'd2,  3'd0, -1, 1'b1, 8,  9,   3};
        vecs[5] = '{4'b1100, 4'd0,  3'd5, -1, 1'b0, 0,  1,   0};
        vecs[6] = '{4'b0110, 4'd15, 3'd7, -1, 1'b0, 60, 159, 0};

        @(posedge clk); #1;
        @(negedge clk);
        check("reset", {out, out_valid, busy, done}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {out, out_valid, busy, done}, 4'b0000);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run(vecs[i].pat, vecs[i].n, vecs[i].g, vecs[i].abort_at, vecs[i].poke, nv, dc, ht);
            check_int($sformatf("vec%0d_valid", i), nv, vecs[i].exp_valid);
            check_int($sformatf("vec%0d_done", i), dc, vecs[i].exp_done);
            check_int($sformatf("vec%0d_hits", i), ht, vecs[i].exp_hits);
        end

        // abort in IDLE blocks an accept
        start = 1'b1; abort = 1'b1; pattern = 4'b1010; reps = 4'd1; gap = 3'd0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_blocks_accept", {out, out_valid, busy, done}, 4'b0000);
        $display("xfer abort_in_idle start blocked");
        @(posedge clk); #1;

        // rst during GAP
        start = 1'b1; pattern = 4'b1010; reps = 4'd2; gap = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        check("in_gap", {out, out_valid, busy, done}, 4'b0010);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_gap", {out, out_valid, busy, done}, 4'b0000);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_no_done", {out, out_valid, busy, done}, 4'b0000);
        $display("xfer rst_during_gap");
        @(posedge clk); #1;
        run(4'b1010, 4'd1, 3'd0, -1, 1'b0, nv, dc, ht);
        check_int("post_rst_valid", nv, 4);

        for (int t = 0; t < 25; t++) begin
            rn = 4'($urandom_range(0, 5));
            a  = -1;
            if (rn != 0 && $urandom_range(0, 3) == 0) a = $urandom_range(1, int'(rn) * 4);
            run(4'($urandom), rn, 3'($urandom_range(0, 3)), a, 1'($urandom), nv, dc, ht);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
